// File: rtl/mem_pkg.sv
// Shared definitions for the memory access path.
//   DATAW          core-side datapath width
//   SZ_*           request size encodings
//   state_t        controller state encoding
//   beat_count()   number of memory beats for a size at a given word width
//                  (0 means the access cannot be performed)
package mem_pkg;

  localparam int unsigned DATAW = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RWAIT,
    RESP
  } state_t;

  function automatic logic [2:0] beat_count(input logic [1:0] size,
                                            input int unsigned wordsize);
    int unsigned bits;
    case (size)
      SZ_BYTE: bits = 8;
      SZ_HALF: bits = 16;
      SZ_WORD: bits = 32;
      default: bits = 0;
    endcase
    if (wordsize == 0 || bits < wordsize) return '0;
    return 3'(bits / wordsize);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Combinational load-data extender.
//   data  raw right-aligned load data
//   size  SZ_BYTE / SZ_HALF / SZ_WORD
//   uns   1 = zero-extend, 0 = sign-extend
//   ext   extended 32-bit result
module load_extend
  import mem_pkg::*;
(
  input  logic [DATAW-1:0] data,
  input  logic [1:0]       size,
  input  logic             uns,
  output logic [DATAW-1:0] ext
);

  always_comb begin
    ext = data;
    case (size)
      SZ_BYTE: ext = {{24{~uns & data[7]}}, data[7:0]};
      SZ_HALF: ext = {{16{~uns & data[15]}}, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the memory_unit port. Accepts one load/store request,
// splits it into WORDSIZE-wide little-endian beats, reassembles load data,
// extends it and returns a one-cycle response.
//   clk, rst              clock, asynchronous active-low reset
//   req_*                 core request (valid/ready), store data right-aligned
//   rsp_valid/rdata/err   single-cycle completion, rdata held until next response
//   mem_wren/rden/addr/d  memory strobes, address and write data (registered)
//   mem_q                 memory read data, RD_LAT cycles after a read beat
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDRSIZE = 16,
  parameter int unsigned WORDSIZE = 8,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDRSIZE-1:0] req_addr,
  input  logic [DATAW-1:0]    req_wdata,
  output logic                rsp_valid,
  output logic [DATAW-1:0]    rsp_rdata,
  output logic                rsp_err,
  output logic                mem_wren,
  output logic                mem_rden,
  output logic [ADDRSIZE-1:0] mem_addr,
  output logic [WORDSIZE-1:0] mem_d,
  input  logic [WORDSIZE-1:0] mem_q
);

  localparam logic [3:0] RDL   = RD_LAT[3:0];
  localparam int unsigned LANES = DATAW / WORDSIZE;

  state_t           state;
  logic [2:0]       n_r;
  logic [1:0]       size_r;
  logic             uns_r;
  logic [DATAW-1:0] wsh;
  logic [DATAW-1:0] asm_r;
  logic [2:0]       iss_cnt;
  logic [2:0]       cap_cnt;
  logic [3:0]       cyc;

  logic [2:0]       nbeat;
  logic             acc_err;
  logic             cap_now;
  logic             last_cap;
  logic [DATAW-1:0] asm_nxt;
  logic [DATAW-1:0] ext_data;

  assign req_ready = (state == IDLE);

  // Beat counts are 1, 2 or 4, so alignment only looks at the low two bits.
  always_comb begin
    nbeat   = beat_count(req_size, WORDSIZE);
    acc_err = (nbeat == 3'd0) ||
              ((req_addr[1:0] & (nbeat[1:0] - 2'd1)) != 2'b00);
  end

  // Captures are back-to-back, so the beat landing in cycle c is always
  // cap_cnt once c has passed the read latency.
  always_comb begin
    cap_now  = ((state == RD) || (state == RWAIT)) && (cyc > RDL);
    last_cap = cap_now && (cap_cnt == n_r - 3'd1);
    asm_nxt  = asm_r;
    if (cap_now) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (cap_cnt == i[2:0]) asm_nxt[i*WORDSIZE +: WORDSIZE] = mem_q;
      end
    end
  end

  load_extend u_ext (
    .data (asm_nxt),
    .size (size_r),
    .uns  (uns_r),
    .ext  (ext_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      n_r       <= '0;
      size_r    <= '0;
      uns_r     <= 1'b0;
      wsh       <= '0;
      asm_r     <= '0;
      iss_cnt   <= '0;
      cap_cnt   <= '0;
      cyc       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_wren  <= 1'b0;
      mem_rden  <= 1'b0;
      mem_addr  <= '0;
      mem_d     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            n_r     <= nbeat;
            size_r  <= req_size;
            uns_r   <= req_unsigned;
            iss_cnt <= '0;
            cap_cnt <= '0;
            cyc     <= 4'd1;
            asm_r   <= '0;
            if (acc_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_we) begin
              state    <= WR;
              mem_wren <= 1'b1;
              mem_addr <= req_addr;
              mem_d    <= req_wdata[WORDSIZE-1:0];
              wsh      <= req_wdata >> WORDSIZE;
            end else begin
              state    <= RD;
              mem_rden <= 1'b1;
              mem_addr <= req_addr;
            end
          end
        end
        WR: begin
          if (iss_cnt == n_r - 3'd1) begin
            mem_wren  <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end else begin
            iss_cnt  <= iss_cnt + 3'd1;
            mem_addr <= mem_addr + ADDRSIZE'(1);
            mem_d    <= wsh[WORDSIZE-1:0];
            wsh      <= wsh >> WORDSIZE;
          end
        end
        RD, RWAIT: begin
          cyc <= cyc + 4'd1;
          if (cap_now) begin
            asm_r   <= asm_nxt;
            cap_cnt <= cap_cnt + 3'd1;
          end
          if (state == RD) begin
            if (iss_cnt == n_r - 3'd1) begin
              mem_rden <= 1'b0;
              state    <= RWAIT;
            end else begin
              iss_cnt  <= iss_cnt + 3'd1;
              mem_addr <= mem_addr + ADDRSIZE'(1);
            end
          end
          // With zero read latency the last capture coincides with the last
          // issue, so this overrides the RWAIT transition above.
          if (last_cap) begin
            mem_rden  <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= ext_data;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_wren;
  logic        mem_rden;
  logic [15:0] mem_addr;
  logic [7:0]  mem_d;
  logic [7:0]  mem_q;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] wa [$];
  logic [7:0]  wdq [$];
  int          wc [$];
  logic [15:0] ra [$];
  int          rc [$];
  int          both_hi = 0;

  mem_access_ctrl #(.ADDRSIZE(16), .WORDSIZE(8), .RD_LAT(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_wren     (mem_wren),
    .mem_rden     (mem_rden),
    .mem_addr     (mem_addr),
    .mem_d        (mem_d),
    .mem_q        (mem_q)
  );

  always #5 clk = ~clk;

  // memory_unit responder: one-cycle registered read
  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_d;
    if (mem_rden) mem_q <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one request from IDLE and follows it until rsp_valid (bounded).
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [15:0] addr, input logic [31:0] wd,
                         output int rcyc, output logic rerr, output logic [31:0] rdat);
    wa.delete(); wdq.delete(); wc.delete(); ra.delete(); rc.delete();
    rcyc = -1; rerr = 1'bx; rdat = 'x;
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (mem_wren && mem_rden) both_hi++;
      if (mem_wren) begin wa.push_back(mem_addr); wdq.push_back(mem_d); wc.push_back(c); end
      if (mem_rden) begin ra.push_back(mem_addr); rc.push_back(c); end
      if (rsp_valid) begin
        rcyc = c; rerr = rsp_err; rdat = rsp_rdata;
        break;
      end
    end
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [15:0] addr, input int exp_cyc, input logic [31:0] exp_dat);
    int cy; logic e; logic [31:0] d;
    run_req(1'b0, sz, uns, addr, 32'd0, cy, e, d);
    check({tag, "_cyc"}, cy, exp_cyc);
    check({tag, "_err"}, {31'd0, e}, 32'd0);
    check({tag, "_data"}, d, exp_dat);
  endtask

  initial begin
    int cy; logic e; logic [31:0] d;
    int seen;
    logic [7:0] exp_d [4];
    logic [7:0] exp5 [4];

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_wren", {31'd0, mem_wren}, 32'd0);
    check("rst_rden", {31'd0, mem_rden}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    rst = 1'b1;

    // 1: word store
    run_req(1'b1, 2'b10, 1'b0, 16'h0010, 32'hA1B2C3D4, cy, e, d);
    exp_d = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    check("st_beats", wa.size(), 4);
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      check($sformatf("st_addr%0d", i), {16'd0, wa[i]}, 32'h10 + i);
      check($sformatf("st_d%0d", i), {24'd0, wdq[i]}, {24'd0, exp_d[i]});
      check($sformatf("st_cyc%0d", i), wc[i], i + 1);
    end
    check("st_rd_strobes", ra.size(), 0);
    check("st_rsp_cyc", cy, 5);
    check("st_err", {31'd0, e}, 32'd0);
    check("st_rdata", d, 32'd0);
    @(negedge clk);
    check("idle_addr_hold", {16'd0, mem_addr}, 32'h13);
    check("idle_d_hold", {24'd0, mem_d}, 32'hA1);
    check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);

    // 2: byte and word loads
    load_chk("lb_s", 2'b00, 1'b0, 16'h0013, 3, 32'hFFFFFFA1);
    load_chk("lb_u", 2'b00, 1'b1, 16'h0013, 3, 32'h000000A1);
    load_chk("lw", 2'b10, 1'b0, 16'h0010, 6, 32'hA1B2C3D4);
    check("lw_rd_beats", ra.size(), 4);
    for (int i = 0; i < 4 && i < ra.size(); i++)
      check($sformatf("lw_raddr%0d", i), {16'd0, ra[i]}, 32'h10 + i);
    @(negedge clk);
    check("rdata_hold", rsp_rdata, 32'hA1B2C3D4);

    // 3: half loads
    load_chk("lh_s", 2'b01, 1'b0, 16'h0012, 4, 32'hFFFFA1B2);
    load_chk("lh_u", 2'b01, 1'b1, 16'h0012, 4, 32'h0000A1B2);

    // 4: misaligned word and illegal size
    run_req(1'b0, 2'b10, 1'b0, 16'h0011, 32'd0, cy, e, d);
    check("mis_cyc", cy, 1);
    check("mis_err", {31'd0, e}, 32'd1);
    check("mis_rdata", d, 32'd0);
    check("mis_strobes", wa.size() + ra.size(), 0);
    run_req(1'b1, 2'b11, 1'b0, 16'h0010, 32'hFFFFFFFF, cy, e, d);
    check("ill_cyc", cy, 1);
    check("ill_err", {31'd0, e}, 32'd1);
    check("ill_rdata", d, 32'd0);
    check("ill_strobes", wa.size() + ra.size(), 0);
    run_req(1'b0, 2'b01, 1'b0, 16'h0013, 32'd0, cy, e, d);
    check("mis_half_err", {31'd0, e}, 32'd1);

    // 5: top of address space
    run_req(1'b1, 2'b10, 1'b0, 16'hFFFC, 32'h12345678, cy, e, d);
    exp5 = '{8'h78, 8'h56, 8'h34, 8'h12};
    check("top_beats", wa.size(), 4);
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      check($sformatf("top_addr%0d", i), {16'd0, wa[i]}, 32'hFFFC + i);
      check($sformatf("top_d%0d", i), {24'd0, wdq[i]}, {24'd0, exp5[i]});
    end
    check("top_rsp_cyc", cy, 5);
    load_chk("top_lw", 2'b10, 1'b0, 16'hFFFC, 6, 32'h12345678);

    // 6: reset during second beat of a word load
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 16'h0010;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst6_beat2_rden", {31'd0, mem_rden}, 32'd1);
    check("rst6_beat2_addr", {16'd0, mem_addr}, 32'h11);
    rst = 1'b0;
    #1;
    check("rst6_rden", {31'd0, mem_rden}, 32'd0);
    check("rst6_wren", {31'd0, mem_wren}, 32'd0);
    check("rst6_addr", {16'd0, mem_addr}, 32'd0);
    check("rst6_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rst6_rdata", rsp_rdata, 32'd0);
    check("rst6_err", {31'd0, rsp_err}, 32'd0);
    check("rst6_ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    repeat (2) begin @(negedge clk); if (rsp_valid) seen++; end
    rst = 1'b1;
    repeat (6) begin @(negedge clk); if (rsp_valid) seen++; end
    check("rst6_no_rsp", seen, 0);
    check("rst6_ready_after", {31'd0, req_ready}, 32'd1);
    load_chk("rst6_lb", 2'b00, 1'b0, 16'h0010, 3, 32'hFFFFFFD4);

    check("never_both_strobes", both_hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the memory_unit port: drives wren/rden/addr/d and consumes q.
- Accepts one 32-bit-datapath load/store request from the core over a valid/ready handshake.
- Splits the request into WORDSIZE-wide memory beats (little-endian) and reassembles read data.
- Sign- or zero-extends load data and returns a single-cycle response.

Parameters:
- ADDRSIZE, 16, width of the memory-word address, shared with memory_unit.
- WORDSIZE, 8, memory word width. Legal values are 8, 16 and 32.
- RD_LAT, 1, cycles from a beat with mem_rden=1 to valid mem_q for that beat. Legal range is 0..3.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle; request accepted when req_valid & req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDRSIZE  base memory-word address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle pulse marking request completion.
- rsp_rdata  out  32  extended load data. 0 for stores and errors. Held until the next response.
- rsp_err  out  1  valid with rsp_valid: illegal size or misalignment.
- mem_wren  out  1  memory write strobe.
- mem_rden  out  1  memory read strobe.
- mem_addr  out  ADDRSIZE  memory address.
- mem_d  out  WORDSIZE  memory write data.
- mem_q  in  WORDSIZE  memory read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, req_ready=1.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_wren=0, mem_rden=0, mem_addr=0, mem_d=0.
  - All beat counters cleared.
  - Any in-flight request is dropped with no response.
- States are IDLE, WR, RD, RWAIT and RESP. req_ready = (state==IDLE). All other outputs are registered.
- Acceptance:
  - Request fields are latched only in IDLE when req_valid=1.
  - Beat count N = access_bits / WORDSIZE.
- Error check at acceptance. Any of the following sends the controller to RESP with rsp_err=1 and no memory strobe:
  - size==11;
  - access_bits < WORDSIZE;
  - req_addr not a multiple of N.
- WR (accept cycle = 0):
  - Beats k=0..N-1 in cycles 1..N.
  - Each beat drives mem_wren=1, mem_addr=base+k, mem_d=wdata[k*WORDSIZE +: WORDSIZE].
  - After the last beat go to RESP. rsp_valid is in cycle N+1.
- RD:
  - Beats k=0..N-1 in cycles 1..N with mem_rden=1 and mem_addr=base+k.
  - Beat k is captured from mem_q in cycle k+1+RD_LAT into lane k of a 32-bit assembly register.
  - After the last issue, wait in RWAIT until all N beats are captured, then go to RESP. rsp_valid is in cycle N+RD_LAT+1.
- Extension:
  - byte: bit 7 is extended to 32 bits.
  - half: bit 15 is extended.
  - word: passed unchanged.
  - req_unsigned selects zero-extension instead of sign-extension.
- RESP:
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
  - No response backpressure.
  - Earliest next acceptance is the cycle after RESP.
- Address arithmetic is modulo 2^ADDRSIZE: base+k wraps from all-ones to 0.
- Memory strobes:
  - mem_wren and mem_rden are never both 1.
  - Both are 0 outside WR and RD.
  - mem_addr and mem_d hold their last value when idle.
- req_valid or field changes while not IDLE are ignored.

Decomposition:
- mem_pkg holds:
  - SZ_BYTE/SZ_HALF/SZ_WORD constants;
  - the state encoding;
  - DATAW=32;
  - a function returning the beat count from size and WORDSIZE.
- One natural sub-module, load_extend: a combinational size/unsigned extender, reusable by the core writeback.
- Counters and the FSM stay in mem_access_ctrl.

Test Plan (WORDSIZE=8, RD_LAT=1, ADDRSIZE=16, memory_unit as responder):
1. Word store, addr 0x0010, data 0xA1B2C3D4 -> cycles 1-4 show mem_wren=1 with addr 0x10-0x13 and d D4,C3,B2,A1; rsp_valid in cycle 5; rsp_err=0; rsp_rdata=0.
2. After 1, byte load at 0x0013: signed -> rsp_rdata=0xFFFFFFA1 in cycle 3; unsigned -> 0x000000A1. Word load at 0x0010 -> 0xA1B2C3D4 in cycle 6.
3. Half load at 0x0012: signed -> 0xFFFFA1B2; unsigned -> 0x0000A1B2.
4. Word load at 0x0011, and separately size=11 -> rsp_valid, rsp_err=1, rsp_rdata=0 in cycle 1; mem_wren and mem_rden never asserted.
5. Word store 0x12345678 at 0xFFFC -> addresses FFFC, FFFD, FFFE, FFFF (no overflow into 0x0000); word load at 0xFFFC returns 0x12345678.
6. rst driven low during the second beat of a word load -> all outputs 0 immediately and no rsp_valid; after release req_ready=1, and a byte load at 0x0010 returns 0xFFFFFFD4.
